// File: rtl/truth_scan_pkg.sv
// Shared types and sizing for the truth-table scanner.
// FSM states, vector count and counter widths live here.
package truth_scan_pkg;

    localparam int NUM_VECTORS = 16;
    localparam int IDX_W       = 4;
    localparam int CNT_W       = 5;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that holds each stimulus vector for SETTLE_CYCLES clocks.
// Loaded on entry to SETTLE; expire flags the final settle cycle.
module settle_timer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam logic [3:0] RELOAD = 4'(SETTLE_CYCLES - 1);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (run && cnt != '0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Sweeps abcd through all 16 vectors and compares f_in against a golden mask.
// Define FIRST_FAIL_CAPTURE_EN to add the first_fail_vld/first_fail_idx outputs.
module truth_table_scanner
    import truth_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        f_in,
    output logic [3:0]  abcd,
    output logic        busy,
    output logic        done,
    output logic [15:0] minterms,
    output logic [4:0]  mismatch_count,
    output logic        pass
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    output logic        first_fail_vld,
    output logic [3:0]  first_fail_idx
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_VECTORS);

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        exp_q;
    logic               load;
    logic               expire;
    logic               accept;
    logic               err;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .run   (state == SETTLE),
        .expire(expire)
    );

    assign accept = (state == IDLE) && start;
    assign err    = (f_in != exp_q[idx]);
    assign abcd   = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SETTLE;
                    load     = 1'b1;
                end
            end
            SETTLE: begin
                if (expire) begin
                    state_nx = SAMPLE;
                end
            end
            SAMPLE: begin
                if (idx == LAST_IDX) begin
                    state_nx = DONE;
                end else begin
                    state_nx = SETTLE;
                    load     = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx            <= '0;
            exp_q          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            minterms       <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                exp_q          <= expected;
                minterms       <= '0;
                mismatch_count <= '0;
                pass           <= 1'b0;
                idx            <= '0;
                busy           <= 1'b1;
            end
            if (state == SAMPLE) begin
                minterms[idx] <= f_in;
                if (err && mismatch_count != MAX_CNT) begin
                    mismatch_count <= mismatch_count + 5'd1;
                end
                // index parks at 15 through DONE; it is zeroed on exit
                if (idx != LAST_IDX) begin
                    idx <= idx + 4'd1;
                end
            end
            if (state == DONE) begin
                done <= 1'b1;
                pass <= (mismatch_count == '0);
                busy <= 1'b0;
                idx  <= '0;
            end
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (accept) begin
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
        end else if (state == SAMPLE && err && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_idx <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: two scanners (SETTLE_CYCLES 1 and 3) against a sweep model.
// Build with FIRST_FAIL_CAPTURE_EN defined to also cover the first-fail outputs.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            start;
    logic [15:0]     expected;
    int              fmode;
    logic [1:0]      f_in;
    logic [1:0][3:0] o_abcd;
    logic [1:0]      o_busy;
    logic [1:0]      o_done;
    logic [1:0]      o_pass;
    logic [1:0][15:0] o_min;
    logic [1:0][4:0] o_cnt;
`ifdef FIRST_FAIL_CAPTURE_EN
    logic [1:0]      o_ffv;
    logic [1:0][3:0] o_ffi;
`endif

    int tests = 0;
    int fails = 0;

    // function under test, written as a minimized sum of products
    function automatic logic f_gate(int mode, logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (mode)
            0: return (!b && !c && !d) || (!a && !b && !d) || (!a && !c && !d)
                   || (a && !b && d) || (a && !c && d);
            1: return 1'b1;
            default: return ^v;
        endcase
    endfunction

    function automatic logic f_ref(int mode, int i);
        case (mode)
            0: return i inside {0, 2, 4, 8, 9, 11, 13};
            1: return 1'b1;
            default: return ($countones(i) % 2) == 1;
        endcase
    endfunction

    assign f_in[0] = f_gate(fmode, o_abcd[0]);
    assign f_in[1] = f_gate(fmode, o_abcd[1]);

    truth_table_scanner #(.SETTLE_CYCLES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .f_in(f_in[0]), .abcd(o_abcd[0]), .busy(o_busy[0]), .done(o_done[0]),
        .minterms(o_min[0]), .mismatch_count(o_cnt[0]), .pass(o_pass[0])
`ifdef FIRST_FAIL_CAPTURE_EN
        , .first_fail_vld(o_ffv[0]), .first_fail_idx(o_ffi[0])
`endif
    );

    truth_table_scanner #(.SETTLE_CYCLES(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected),
        .f_in(f_in[1]), .abcd(o_abcd[1]), .busy(o_busy[1]), .done(o_done[1]),
        .minterms(o_min[1]), .mismatch_count(o_cnt[1]), .pass(o_pass[1])
`ifdef FIRST_FAIL_CAPTURE_EN
        , .first_fail_vld(o_ffv[1]), .first_fail_idx(o_ffi[1])
`endif
    );

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // sweep model: cycle count since acceptance plus end-of-sweep results
    int          m_t[2];
    bit          m_act[2];
    bit          m_dn[2];
    logic [15:0] m_exp[2];
    logic [15:0] m_min[2];
    int          m_cnt[2];
    bit          m_pass[2];
    bit          m_ffv[2];
    int          m_ffi[2];
    int          m_mode[2];

    function automatic int settle(int j);
        return (j == 0) ? 1 : 3;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int j = 0; j < 2; j++) begin
            if (!rst_n) begin
                m_t[j] = 0; m_act[j] = 0; m_dn[j] = 0; m_exp[j] = '0;
                m_min[j] = '0; m_cnt[j] = 0; m_pass[j] = 0;
                m_ffv[j] = 0; m_ffi[j] = 0; m_mode[j] = 0;
            end else begin
                m_dn[j] = 0;
                if (m_act[j]) begin
                    m_t[j]++;
                    if (m_t[j] == 16 * (settle(j) + 1) + 1) begin
                        m_act[j] = 0;
                        m_dn[j]  = 1;
                        for (int i = 0; i < 16; i++) begin
                            logic b;
                            b = f_ref(m_mode[j], i);
                            m_min[j][i] = b;
                            if (b != m_exp[j][i]) begin
                                m_cnt[j]++;
                                if (!m_ffv[j]) begin
                                    m_ffv[j] = 1;
                                    m_ffi[j] = i;
                                end
                            end
                        end
                        m_pass[j] = (m_cnt[j] == 0);
                    end
                end else if (start) begin
                    m_act[j] = 1; m_t[j] = 0;
                    m_exp[j] = expected; m_mode[j] = fmode;
                    m_min[j] = '0; m_cnt[j] = 0; m_pass[j] = 0;
                    m_ffv[j] = 0; m_ffi[j] = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int j = 0; j < 2; j++) begin
                int n, ea;
                n  = 16 * (settle(j) + 1);
                ea = !m_act[j] ? 0 : (m_t[j] < n) ? m_t[j] / (settle(j) + 1) : 15;
                chk($sformatf("abcd%0d", j), 32'(o_abcd[j]), 32'(ea));
                chk($sformatf("busy%0d", j), 32'(o_busy[j]), 32'(m_act[j]));
                chk($sformatf("done%0d", j), 32'(o_done[j]), 32'(m_dn[j]));
                if (!m_act[j]) begin
                    chk($sformatf("minterms%0d", j), 32'(o_min[j]), 32'(m_min[j]));
                    chk($sformatf("count%0d", j), 32'(o_cnt[j]), 32'(m_cnt[j]));
                    chk($sformatf("pass%0d", j), 32'(o_pass[j]), 32'(m_pass[j]));
`ifdef FIRST_FAIL_CAPTURE_EN
                    chk($sformatf("ffv%0d", j), 32'(o_ffv[j]), 32'(m_ffv[j]));
                    chk($sformatf("ffi%0d", j), 32'(o_ffi[j]), 32'(m_ffi[j]));
`endif
                end
            end
        end
    end

    task automatic check_zero(string tag);
        chk({tag, "_abcd"}, 32'(o_abcd), 32'h0);
        chk({tag, "_busy"}, 32'(o_busy), 32'h0);
        chk({tag, "_done"}, 32'(o_done), 32'h0);
        chk({tag, "_min"}, o_min, 32'h0);
        chk({tag, "_cnt"}, 32'(o_cnt), 32'h0);
        chk({tag, "_pass"}, 32'(o_pass), 32'h0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk({tag, "_ffv"}, 32'(o_ffv), 32'h0);
        chk({tag, "_ffi"}, 32'(o_ffi), 32'h0);
`endif
    endtask

    task automatic run(input int mode, input logic [15:0] ex, input bit poke,
                       output int lat0, output int lat1,
                       output int nd0, output int nd1);
        lat0 = -1; lat1 = -1; nd0 = 0; nd1 = 0;
        @(negedge clk);
        fmode = mode; expected = ex; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            if (o_done[0]) begin nd0++; if (lat0 < 0) lat0 = c; end
            if (o_done[1]) begin nd1++; if (lat1 < 0) lat1 = c; end
            if (poke && c == 10) begin start = 1'b1; expected = ~ex; end
            if (poke && c == 11) start = 1'b0;
        end
    endtask

    int  l0, l1, d0, d1;
    bit  hit;

    initial begin
        rst_n = 1'b1; start = 1'b0; expected = '0; fmode = 0;
        #1 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, 16'h2B15, 0, l0, l1, d0, d1);
        chk("sop_min", 32'(o_min[0]), 32'h2B15);
        chk("sop_cnt", 32'(o_cnt[0]), 32'd0);
        chk("sop_pass", 32'(o_pass[0]), 32'd1);
        chk("lat_s1", l0, 33);
        chk("lat_s3", l1, 65);
        chk("ndone_s1", d0, 1);

        run(0, 16'h2B14, 0, l0, l1, d0, d1);
        chk("err1_cnt", 32'(o_cnt[0]), 32'd1);
        chk("err1_pass", 32'(o_pass[0]), 32'd0);
`ifdef FIRST_FAIL_CAPTURE_EN
        chk("err1_ffi", 32'(o_ffi[0]), 32'd0);
        chk("err1_ffv", 32'(o_ffv[0]), 32'd1);
`endif

        run(1, 16'h0000, 0, l0, l1, d0, d1);
        chk("ones_min", 32'(o_min[0]), 32'hFFFF);
        chk("ones_cnt", 32'(o_cnt[0]), 32'd16);
        chk("ones_cnt_s3", 32'(o_cnt[1]), 32'd16);

        run(2, 16'h6996, 1, l0, l1, d0, d1);
        chk("poke_cnt", 32'(o_cnt[0]), 32'd0);
        chk("poke_pass", 32'(o_pass[1]), 32'd1);
        chk("poke_nd_s1", d0, 1);
        chk("poke_nd_s3", d1, 1);
        chk("poke_lat_s3", l1, 65);

        @(negedge clk);
        fmode = 0; expected = 16'h2B15; start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        hit = 0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(posedge clk);
            #1;
            if (o_abcd[0] == 4'd7) hit = 1;
        end
        chk("idx7_reached", 32'(hit), 32'd1);
        #1 rst_n = 1'b0;
        #1 check_zero("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        run(0, 16'h2B14, 0, l0, l1, d0, d1);
        chk("fresh_cnt", 32'(o_cnt[0]), 32'd1);
        chk("fresh_lat", l0, 33);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL provide parameter SETTLE_CYCLES, default 1, which sets the number of clock cycles abcd is held stable before f_in is sampled (legal range 1..15).
REQ-002 The block SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL provide port start, input, 1 bit: request one full 16-vector sweep.
REQ-005 The block SHALL provide port expected, input, 16 bits: golden minterm mask; bit i is the expected f for abcd==i.
REQ-006 The block SHALL provide port f_in, input, 1 bit: output of the combinational 4-input function under test.
REQ-007 The block SHALL provide port abcd, output, 4 bits: stimulus to the function, {a,b,c,d} with a as MSB.
REQ-008 The block SHALL provide port busy, output, 1 bit: a sweep is in progress.
REQ-009 The block SHALL provide port done, output, 1 bit: single-cycle pulse marking sweep completion.
REQ-010 The block SHALL provide port minterms, output, 16 bits: captured f for each vector.
REQ-011 The block SHALL provide port mismatch_count, output, 5 bits: number of vectors where the captured f differs from expected (0..16).
REQ-012 The block SHALL provide port pass, output, 1 bit: high when the last completed sweep had mismatch_count==0.

Function
REQ-013 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE with start=1, the block SHALL latch expected, clear minterms and mismatch_count, clear pass, set index and abcd to 0, assert busy and enter SETTLE.
REQ-015 SETTLE SHALL last exactly SETTLE_CYCLES cycles, holding abcd constant, then enter SAMPLE.
REQ-016 In SAMPLE (one cycle) the block SHALL write f_in to minterms[index] and increment mismatch_count when f_in != latched expected[index].
REQ-017 After SAMPLE, if index<15 the block SHALL increment index and abcd and return to SETTLE; if index==15 it SHALL enter DONE with no wrap to 0.
REQ-018 In DONE (one cycle) the block SHALL assert done, update pass, deassert busy at the next edge, drive abcd to 0 and return to IDLE.
REQ-019 The done pulse SHALL appear 16*(SETTLE_CYCLES+1)+1 cycles after the edge that accepted start.
REQ-020 start SHALL be ignored while busy=1 or in DONE; changes to expected during a sweep SHALL have no effect.
REQ-021 minterms, mismatch_count and pass SHALL hold their values from the end of one sweep until the next start is accepted.
REQ-022 mismatch_count SHALL never exceed 16 and SHALL not wrap.

Reset
REQ-023 While rst_n=0, regardless of clk, the block SHALL force state IDLE, abcd=0, busy=0, done=0, minterms=0, mismatch_count=0 and pass=0.
REQ-024 Reset asserted mid-sweep SHALL abort the sweep, with no done pulse and no partial results retained.

Configuration
REQ-025 With FIRST_FAIL_CAPTURE_EN defined, the block SHALL add outputs first_fail_vld (1 bit) and first_fail_idx (4 bits), cleared on reset and on start, which record the index of the first mismatching vector in a sweep.
REQ-026 Without FIRST_FAIL_CAPTURE_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package truth_scan_pkg SHALL hold the FSM state enum, NUM_VECTORS=16, IDX_W=4 and CNT_W=5.
REQ-028 A sub-module settle_timer SHALL implement the SETTLE_CYCLES down-counter, with load and expire signals.

Verification
REQ-029 Connect the minimized 4-input SOP function, expected=16'h2B15, SETTLE_CYCLES=1, pulse start -> minterms=16'h2B15, mismatch_count=0, pass=1, done exactly 33 cycles after start.
REQ-030 Same DUT, expected=16'h2B14 -> mismatch_count=1, pass=0; with FIRST_FAIL_CAPTURE_EN, first_fail_idx=0 and first_fail_vld=1.
REQ-031 Tie f_in=1 with expected=16'h0000 -> minterms=16'hFFFF, mismatch_count=16, no wrap to 0.
REQ-032 Pulse start again at cycle 10 of a sweep and change expected mid-sweep -> sweep unaffected, single done pulse.
REQ-033 Deassert rst_n while index==7 -> all outputs 0 immediately (asynchronously), no done pulse; a fresh start then completes normally.
REQ-034 SETTLE_CYCLES=3 -> abcd steps every 4 cycles through 0..15 in order, and done arrives 65 cycles after start.
